// File: rtl/btn_debounce.sv
// Button front end: two-flop synchronisers, per-button stability filters with press pulses,
// and a post-command lockout timer that reports completion once both buttons are released.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic c_raw,
  input  logic ss_raw,
  input  logic strt_pls,
  output logic c_btn,
  output logic ss_btn,
  output logic db_done,
  output logic busy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {LIdle, LCount, LWrel, LDone} lock_state_e;

  // Bit 0 is the clear button, bit 1 is start/stop.
  logic [1:0]            s1_q, s1_d, s2_q, s2_d;
  logic [1:0]            lvl_q, lvl_d;
  logic [1:0]            pls_q, pls_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  lock_state_e           state_q, state_d;
  logic [CNT_W-1:0]      tcnt_q, tcnt_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  always_comb begin
    s1_d  = {ss_raw, c_raw};
    s2_d  = s1_q;
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    pls_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          lvl_d[i] = s2_q[i];
          cnt_d[i] = '0;
          // A press qualified during lockout still updates the level but is dropped.
          pls_d[i] = s2_q[i] & ~busy_q;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      LIdle: begin
        if (strt_pls) begin
          state_d = LCount;
          tcnt_d  = '0;
        end
      end
      LCount: begin
        if (strt_pls) begin
          tcnt_d = '0;
        end else if (tcnt_q == CntMax) begin
          state_d = LWrel;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      LWrel: begin
        if (strt_pls) begin
          state_d = LCount;
          tcnt_d  = '0;
        end else if (lvl_q == 2'b00) begin
          state_d = LDone;
          done_d  = 1'b1;
        end
      end
      LDone: begin
        state_d = LIdle;
      end
      default: begin
        state_d = LIdle;
      end
    endcase
    busy_d = (state_d != LIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      pls_q   <= '0;
      cnt_q   <= '0;
      state_q <= LIdle;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      lvl_q   <= lvl_d;
      pls_q   <= pls_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign c_btn   = pls_q[0];
  assign ss_btn  = pls_q[1];
  assign db_done = done_q;
  assign busy    = busy_q;

endmodule
